// File: rtl/encrypt_pkg.sv
// ----------------------------------------------------------------------------
// encrypt_pkg
// Shared definitions for the encryption lane:
//   - rc_state_e          : round-controller FSM encoding
//   - BLOCK_WIDTH_DEFAULT : default data / key width
//   - MAX_BLOCK_WIDTH     : widest block the key-schedule helper supports
//   - next_round_key()    : key schedule rk(r+1) = rotl1(rk(r)) ^ (r+1)
// ----------------------------------------------------------------------------
package encrypt_pkg;

    localparam int BLOCK_WIDTH_DEFAULT = 32;
    localparam int MAX_BLOCK_WIDTH     = 128;

    typedef enum logic [1:0] {
        RC_IDLE = 2'd0,
        RC_RUN  = 2'd1,
        RC_DONE = 2'd2
    } rc_state_e;

    // Key schedule step. 'key' holds rk(r) zero-extended to MAX_BLOCK_WIDTH,
    // 'rnd' is r, 'width' is the real block width. The rotate is confined to
    // the low 'width' bits, so the result is zero above bit width-1 and the
    // caller may simply truncate it.
    function automatic logic [MAX_BLOCK_WIDTH-1:0] next_round_key(
        input logic [MAX_BLOCK_WIDTH-1:0] key,
        input logic [31:0]                rnd,
        input int                         width
    );
        logic [MAX_BLOCK_WIDTH-1:0] mask;
        logic [MAX_BLOCK_WIDTH-1:0] rot;
        logic [MAX_BLOCK_WIDTH-1:0] inc;
        mask = {MAX_BLOCK_WIDTH{1'b1}} >> (MAX_BLOCK_WIDTH - width);
        rot  = ((key << 1) | (key >> (width - 1))) & mask;
        inc  = MAX_BLOCK_WIDTH'(rnd + 32'd1);
        return rot ^ inc;
    endfunction

endpackage : encrypt_pkg

// File: rtl/encrypt_engine.sv
// ----------------------------------------------------------------------------
// encrypt_engine
// One combinational encryption round: XOR with the round key, then rotate
// left by one bit.
// Ports:
//   data_in   [BLOCK_WIDTH] : round input state
//   round_key [BLOCK_WIDTH] : key for this round
//   data_out  [BLOCK_WIDTH] : rotl1(data_in ^ round_key)
// ----------------------------------------------------------------------------
module encrypt_engine
    import encrypt_pkg::*;
#(
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEFAULT
) (
    input  logic [BLOCK_WIDTH-1:0] data_in,
    input  logic [BLOCK_WIDTH-1:0] round_key,
    output logic [BLOCK_WIDTH-1:0] data_out
);

    logic [BLOCK_WIDTH-1:0] mixed_s;

    // Key mixing followed by a one-bit left rotate (MSB wraps into bit 0).
    always_comb begin
        mixed_s  = data_in ^ round_key;
        data_out = {mixed_s[BLOCK_WIDTH-2:0], mixed_s[BLOCK_WIDTH-1]};
    end

endmodule : encrypt_engine

// File: rtl/encrypt_round_ctrl.sv
// ----------------------------------------------------------------------------
// encrypt_round_ctrl
// Iterative round controller. Accepts one plaintext/key pair, runs
// NUM_ROUNDS passes through a single encrypt_engine while deriving the round
// keys on the fly, then holds the ciphertext until the consumer takes it.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (ready only in IDLE)
//   in_data, in_key      : plaintext and cipher key
//   out_valid / out_ready: output handshake (valid only in DONE)
//   out_data             : ciphertext (equals the state register at all times)
//   busy                 : high while a block is in RUN or DONE
// All outputs come straight from flops; no input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module encrypt_round_ctrl
    import encrypt_pkg::*;
#(
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEFAULT,
    parameter int NUM_ROUNDS  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BLOCK_WIDTH-1:0] in_data,
    input  logic [BLOCK_WIDTH-1:0] in_key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BLOCK_WIDTH-1:0] out_data,
    output logic                   busy
);

    // Wide enough to hold NUM_ROUNDS; it is reloaded on every accept so it
    // never wraps.
    localparam int               RND_W    = $clog2(NUM_ROUNDS + 1);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

    rc_state_e              fsm_q,       fsm_d;
    logic [BLOCK_WIDTH-1:0] state_q,     state_d;
    logic [BLOCK_WIDTH-1:0] rk_q,        rk_d;
    logic [RND_W-1:0]       rnd_q,       rnd_d;
    logic                   in_ready_q,  in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q,      busy_d;

    logic [BLOCK_WIDTH-1:0] engine_out_s;
    logic [BLOCK_WIDTH-1:0] rk_next_s;

    encrypt_engine #(
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_engine (
        .data_in   (state_q),
        .round_key (rk_q),
        .data_out  (engine_out_s)
    );

    // Next round key from the shared schedule helper; the helper returns a
    // zero-padded wide word, so truncation loses nothing.
    always_comb begin
        rk_next_s = BLOCK_WIDTH'(next_round_key(MAX_BLOCK_WIDTH'(rk_q),
                                                32'(rnd_q),
                                                BLOCK_WIDTH));
    end

    // FSM next-state and datapath next-value decode. The handshake flags are
    // computed here for the *next* state so they can be registered.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rk_d        = rk_q;
        rnd_d       = rnd_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (fsm_q)
            RC_IDLE: begin
                if (in_valid) begin
                    fsm_d       = RC_RUN;
                    state_d     = in_data;
                    rk_d        = in_key;
                    rnd_d       = '0;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b1;
                end else begin
                    fsm_d       = RC_IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            RC_RUN: begin
                state_d = engine_out_s;
                rk_d    = rk_next_s;
                rnd_d   = rnd_q + RND_W'(1);
                if (rnd_q == LAST_RND) begin
                    fsm_d       = RC_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    fsm_d       = RC_RUN;
                    out_valid_d = 1'b0;
                end
                in_ready_d = 1'b0;
                busy_d     = 1'b1;
            end
            RC_DONE: begin
                // Output stays frozen until the consumer takes it; the input
                // side stays closed so no turn-around happens in this cycle.
                if (out_ready) begin
                    fsm_d       = RC_IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else begin
                    fsm_d       = RC_DONE;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            default: begin
                // Illegal encoding: fall back to a clean idle state.
                fsm_d       = RC_IDLE;
                state_d     = '0;
                rk_d        = '0;
                rnd_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State register bank with synchronous reset; reset discards any block
    // in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= RC_IDLE;
            state_q     <= '0;
            rk_q        <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rk_q        <= rk_d;
            rnd_q       <= rnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Outputs are direct flop outputs.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        busy      = busy_q;
        out_data  = state_q;
    end

endmodule : encrypt_round_ctrl
